// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one bit per cycle.
// Multiplies run an unsigned shift-add over operand magnitudes; divides run a
// restoring divider. Signs are re-applied on the final step before the result
// is registered. Divide by zero short-circuits straight to DONE.
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [2:0]                    funct3,
    input  logic [$clog2(NUM_REGS)-1:0]   rd_in,
    input  logic [DATA_WIDTH-1:0]         op_a,
    input  logic [DATA_WIDTH-1:0]         op_b,
    output logic                          busy,
    output logic                          valid,
    output logic [DATA_WIDTH-1:0]         result,
    output logic [$clog2(NUM_REGS)-1:0]   rd_out,
    output logic                          we_out
);

    localparam int W  = DATA_WIDTH;
    localparam int RW = $clog2(NUM_REGS);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [2:0]          r_funct3;
    logic [RW-1:0]       r_rd;
    logic [CW-1:0]       r_cnt;
    logic [W-1:0]        r_opnd;      // multiplicand (mul) or divisor (div) magnitude
    logic [2*W-1:0]      r_acc;       // {high, multiplier} for mul; low half = dividend/quotient for div
    logic [W-1:0]        r_rem;       // partial remainder
    logic                r_neg_q;     // negate product / quotient
    logic                r_neg_r;     // negate remainder

    // Operand decode at accept
    logic                w_is_div;
    logic                w_sign_a;
    logic                w_sign_b;
    logic [W-1:0]        w_a_mag;
    logic [W-1:0]        w_b_mag;
    logic                w_div_zero;
    logic [W-1:0]        w_div_zero_res;

    assign w_is_div   = funct3[2];
    assign w_sign_a   = op_a[W-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                                     (funct3 == 3'b100) | (funct3 == 3'b110));
    assign w_sign_b   = op_b[W-1] & ((funct3 == 3'b001) | (funct3 == 3'b100) |
                                     (funct3 == 3'b110));
    assign w_a_mag    = w_sign_a ? (~op_a + {{(W-1){1'b0}}, 1'b1}) : op_a;
    assign w_b_mag    = w_sign_b ? (~op_b + {{(W-1){1'b0}}, 1'b1}) : op_b;
    assign w_div_zero = w_is_div & (op_b == {W{1'b0}});
    // DIV/DIVU by zero -> all ones, REM/REMU by zero -> dividend unchanged
    assign w_div_zero_res = funct3[1] ? op_a : {W{1'b1}};

    // One shift-add step
    logic [W:0]          w_sum;
    logic [2*W-1:0]      w_acc_next;
    assign w_sum      = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : {(W+1){1'b0}});
    assign w_acc_next = {w_sum, r_acc[W-1:1]};

    // One restoring-division step
    logic [W:0]          w_shift;
    logic [W:0]          w_diff;
    logic                w_qbit;
    logic [W-1:0]        w_rem_next;
    logic [W-1:0]        w_q_next;
    assign w_shift    = {r_rem, r_acc[W-1]};
    assign w_diff     = w_shift - {1'b0, r_opnd};
    assign w_qbit     = ~w_diff[W];
    assign w_rem_next = w_qbit ? w_diff[W-1:0] : w_shift[W-1:0];
    assign w_q_next   = {r_acc[W-2:0], w_qbit};

    // Sign fix-up on the final step
    logic [2*W-1:0]      w_prod_fin;
    logic [W-1:0]        w_q_fin;
    logic [W-1:0]        w_r_fin;
    logic [W-1:0]        w_final;
    assign w_prod_fin = r_neg_q ? (~w_acc_next + {{(2*W-1){1'b0}}, 1'b1}) : w_acc_next;
    assign w_q_fin    = r_neg_q ? (~w_q_next + {{(W-1){1'b0}}, 1'b1}) : w_q_next;
    assign w_r_fin    = r_neg_r ? (~w_rem_next + {{(W-1){1'b0}}, 1'b1}) : w_rem_next;

    logic                w_last;
    assign w_last = (r_cnt == {{(CW-1){1'b0}}, 1'b1});

    // Select the architectural word for the latched opcode
    always_comb begin
        w_final = w_prod_fin[W-1:0];
        case (r_funct3)
            3'b000:                  w_final = w_prod_fin[W-1:0];
            3'b001, 3'b010, 3'b011:  w_final = w_prod_fin[2*W-1:W];
            3'b100, 3'b101:          w_final = w_q_fin;
            3'b110, 3'b111:          w_final = w_r_fin;
            default:                 w_final = w_prod_fin[W-1:0];
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = w_div_zero ? DONE : CALC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = CALC;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath, operand latching and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_funct3 <= 3'b000;
            r_rd     <= {RW{1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_opnd   <= {W{1'b0}};
            r_acc    <= {(2*W){1'b0}};
            r_rem    <= {W{1'b0}};
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            we_out   <= 1'b0;
            result   <= {W{1'b0}};
            rd_out   <= {RW{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        r_funct3 <= funct3;
                        r_rd     <= rd_in;
                        r_neg_q  <= w_sign_a ^ w_sign_b;
                        r_neg_r  <= w_sign_a;
                        r_cnt    <= CW'(W);
                        r_rem    <= {W{1'b0}};
                        if (w_is_div) begin
                            r_opnd <= w_b_mag;
                            r_acc  <= {{W{1'b0}}, w_a_mag};
                        end else begin
                            r_opnd <= w_a_mag;
                            r_acc  <= {{W{1'b0}}, w_b_mag};
                        end
                        if (w_div_zero) begin
                            result <= w_div_zero_res;
                            rd_out <= rd_in;
                            valid  <= 1'b1;
                            we_out <= (rd_in != {RW{1'b0}});
                        end else begin
                            valid  <= 1'b0;
                            we_out <= 1'b0;
                        end
                    end else begin
                        busy   <= 1'b0;
                        valid  <= 1'b0;
                        we_out <= 1'b0;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                    if (r_funct3[2]) begin
                        r_acc <= {r_acc[2*W-1:W], w_q_next};
                        r_rem <= w_rem_next;
                    end else begin
                        r_acc <= w_acc_next;
                    end
                    if (w_last) begin
                        result <= w_final;
                        rd_out <= r_rd;
                        valid  <= 1'b1;
                        we_out <= (r_rd != {RW{1'b0}});
                    end else begin
                        valid  <= 1'b0;
                        we_out <= 1'b0;
                    end
                end
                DONE: begin
                    busy   <= 1'b0;
                    valid  <= 1'b0;
                    we_out <= 1'b0;
                end
                default: begin
                    busy   <= 1'b0;
                    valid  <= 1'b0;
                    we_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
